datapath: RTL and testbench
===========================

# datapath

Four-bit accumulator-style datapath: an input register fed by a 2:1 mux (external data or ALU feedback), a 1:2 demux that steers the register into operand register A or B, and a combinational 3-bit-opcode ALU. It sits under the control FSM (the FSM drives `sel21`, `sel12` and `operacao` each cycle) and produces `resultado` and `carry_out` for the rest of the system.

## Interface
- No parameters; data width fixed at 4 bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high; clears all registers.
- `dados` input 4: external data operand.
- `sel21` input 1: input-mux select; 0 = `dados`, 1 = ALU `resultado` feedback.
- `sel12` input 1: demux select; 0 = load A, 1 = load B.
- `operacao` input 3: ALU opcode.
- `resultado` output 4: ALU result.
- `carry_out` output 1: carry/borrow of ADD/SUB; 0 for other ops.

## Operation
- State: `R` (input register), `A`, `B`, each 4 bits.
- Every rising edge with `rst`=0: `R` <= (`sel21` ? `resultado` : `dados`). Concurrently, if `sel12`=0 then `A` <= `R`, else `B` <= `R`. Non-selected operand holds.
- `R` is loaded every cycle; no enable. A/B always capture the old `R` value (pre-edge).
- ALU, combinational on A, B:
  - 000 AND: A & B
  - 001 OR: A | B
  - 010 ADD: {carry_out, resultado} = A + B (5-bit sum)
  - 011 SUB: resultado = A − B mod 16; carry_out = 1 when A < B (borrow)
  - 100 XOR: A ^ B
  - 101 NOT: ~A
  - 110 PASS A: A
  - 111 PASS B: B
- `carry_out` = 0 for all opcodes other than 010/011.
- Wrap-around: ADD 1111+0001 -> 0000, carry 1; SUB 0000−0001 -> 1111, carry 1.
- Feedback with `sel21`=1 captures the current combinational `resultado` (after this cycle's ALU settling), not a delayed value.

## Timing
- `rst`=1 at an edge: `R`, `A`, `B` <= 0; reset wins over any select. Mid-operation reset discards all state.
- Reset values of outputs (A=B=0): `resultado` = 0000 for opcodes 000–100, 110, 111; 1111 for 101; `carry_out` = 0 for every opcode.
- Latency `dados` -> operand: 2 edges (edge 1 into `R`, edge 2 into A or B); `resultado` valid combinationally after edge 2.
- Opcode change: `resultado`/`carry_out` update combinationally in the same cycle.
- No handshake; controller is responsible for sequencing.

## Configuration
- `DATAPATH_OUT_REG_EN` defined: `resultado` and `carry_out` are registered (reset to 0000/0). Latency becomes 3 edges. Feedback path (`sel21`=1) uses the registered `resultado`.
- Not defined: outputs are combinational as described above.

## Test plan
- Reset: `rst`=1 one edge, `operacao`=010 -> `resultado`=0000, `carry_out`=0; `operacao`=101 -> 1111.
- Load A: `dados`=0011, `sel21`=0, `sel12`=0, `operacao`=010, release reset -> after 2 edges A=0011, `resultado`=0011, carry 0.
- Load B: continue with `sel12`=1 one edge -> B=0011, `resultado`=0110, carry 0.
- Feedback: A=0011, B=0011, `sel21`=1, ADD -> `R`=0110 next edge; following edge with `sel12`=0 -> A=0110, `resultado`=1001.
- Overflow/borrow: A=1111, B=0001: ADD -> 0000 carry 1; SUB -> 1110 carry 0; A=0000,B=0001 SUB -> 1111 carry 1.
- All opcodes with A=1010, B=0110: AND 0010, OR 1110, XOR 1100, NOT 0101, PASS A 1010, PASS B 0110, carry 0; then mid-stream `rst` clears A/B to 0.

Source files
------------

// File: rtl/datapath.sv
// Four-bit accumulator datapath: input register with data/feedback mux, A/B operand demux, 3-bit-opcode ALU.
// Optional DATAPATH_OUT_REG_EN registers resultado/carry_out (and the feedback path uses the registered value).
module datapath (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dados,
    input  logic       sel21,
    input  logic       sel12,
    input  logic [2:0] operacao,
    output logic [3:0] resultado,
    output logic       carry_out
);

    localparam int unsigned W = 4;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_XOR  = 3'b100,
        OP_NOT  = 3'b101,
        OP_PASA = 3'b110,
        OP_PASB = 3'b111
    } op_e;

    logic [W-1:0] r_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] alu_res;
    logic         alu_carry;
    logic [W:0]   wide;
    logic [W-1:0] feedback;

    // ALU; the 5-bit wide result carries ADD's carry and SUB's borrow in its MSB
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        wide      = '0;
        case (op_e'(operacao))
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_ADD: begin
                wide      = {1'b0, a_q} + {1'b0, b_q};
                alu_res   = wide[W-1:0];
                alu_carry = wide[W];
            end
            OP_SUB: begin
                wide      = {1'b0, a_q} - {1'b0, b_q};
                alu_res   = wide[W-1:0];
                alu_carry = wide[W];
            end
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_NOT:  alu_res = ~a_q;
            OP_PASA: alu_res = a_q;
            OP_PASB: alu_res = b_q;
            default: alu_res = '0;
        endcase
    end

`ifdef DATAPATH_OUT_REG_EN
    logic [W-1:0] res_q;
    logic         carry_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            res_q   <= alu_res;
            carry_q <= alu_carry;
        end
    end

    assign resultado = res_q;
    assign carry_out = carry_q;
`else
    assign resultado = alu_res;
    assign carry_out = alu_carry;
`endif

    assign feedback = resultado;

    // Operands capture the pre-edge R value while R reloads every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            r_q <= sel21 ? feedback : dados;
            if (!sel12) a_q <= r_q;
            else        b_q <= r_q;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: arithmetic reference model checked every cycle plus directed literal checks.
module tb_datapath;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dados;
    logic       sel21;
    logic       sel12;
    logic [2:0] operacao;
    logic [3:0] resultado;
    logic       carry_out;

    int checks = 0;
    int errors = 0;

    logic [3:0] m_r, m_a, m_b;
    bit         m_valid = 0;

    datapath dut (
        .clk       (clk),
        .rst       (rst),
        .dados     (dados),
        .sel21     (sel21),
        .sel12     (sel12),
        .operacao  (operacao),
        .resultado (resultado),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    // Reference ALU from plain integer arithmetic: returns {carry, result}
    function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        int s;
        case (op)
            3'd0: return {1'b0, a & b};
            3'd1: return {1'b0, a | b};
            3'd2: begin
                s = int'(a) + int'(b);
                return {1'(s > 15), 4'(s % 16)};
            end
            3'd3: begin
                s = int'(a) - int'(b);
                return {1'(s < 0), 4'((s + 16) % 16)};
            end
            3'd4: return {1'b0, a ^ b};
            3'd5: return {1'b0, ~a};
            3'd6: return {1'b0, a};
            default: return {1'b0, b};
        endcase
    endfunction

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_op(input string name, input logic [2:0] op, input logic [3:0] res, input logic co);
        operacao = op;
        #1;
        check({name, "_res"}, resultado, res);
        check({name, "_carry"}, {3'b000, carry_out}, {3'b000, co});
    endtask

    // Three edges: A <= a, then B <= b
    task automatic load(input logic [3:0] a, input logic [3:0] b);
        sel21 = 1'b0;
        dados = a; sel12 = 1'b1; tick();
        dados = b; sel12 = 1'b0; tick();
        sel12 = 1'b1; tick();
    endtask

    // Model state update at the active edge
    always @(posedge clk) begin
        logic [4:0] e;
        logic [3:0] nr;
        if (rst) begin
            m_r = '0; m_a = '0; m_b = '0;
            m_valid = 1;
        end else if (m_valid) begin
            e  = alu_model(m_a, m_b, operacao);
            nr = sel21 ? e[3:0] : dados;
            if (!sel12) m_a = m_r;
            else        m_b = m_r;
            m_r = nr;
        end
    end

    always @(negedge clk) begin
        logic [4:0] e;
        if (m_valid) begin
            e = alu_model(m_a, m_b, operacao);
            check("cycle_res", resultado, e[3:0]);
            check("cycle_carry", {3'b000, carry_out}, {3'b000, e[4]});
        end
    end

    initial begin
        rst = 1'b1; dados = 4'b0011; sel21 = 1'b0; sel12 = 1'b0; operacao = 3'b010;
        tick();
        expect_op("reset_add", 3'b010, 4'b0000, 1'b0);
        expect_op("reset_not", 3'b101, 4'b1111, 1'b0);
        expect_op("reset_sub", 3'b011, 4'b0000, 1'b0);

        // Load A through R: two edges
        operacao = 3'b010;
        rst = 1'b0; dados = 4'b0011; sel21 = 1'b0; sel12 = 1'b0;
        tick();
        expect_op("load_a_1edge", 3'b010, 4'b0000, 1'b0);
        tick();
        expect_op("load_a", 3'b010, 4'b0011, 1'b0);

        sel12 = 1'b1;
        tick();
        expect_op("load_b", 3'b010, 4'b0110, 1'b0);

        // Feedback: R <= 3+3, then A <= R
        sel21 = 1'b1; sel12 = 1'b0;
        tick();
        expect_op("fb_hold", 3'b010, 4'b0110, 1'b0);
        sel21 = 1'b0; dados = 4'b0001; sel12 = 1'b0;
        tick();
        expect_op("feedback", 3'b010, 4'b1001, 1'b0);

        load(4'b1111, 4'b0001);
        expect_op("ovf_add", 3'b010, 4'b0000, 1'b1);
        expect_op("ovf_sub", 3'b011, 4'b1110, 1'b0);

        load(4'b0000, 4'b0001);
        expect_op("borrow_sub", 3'b011, 4'b1111, 1'b1);
        expect_op("borrow_add", 3'b010, 4'b0001, 1'b0);

        load(4'b1010, 4'b0110);
        expect_op("op_and", 3'b000, 4'b0010, 1'b0);
        expect_op("op_or", 3'b001, 4'b1110, 1'b0);
        expect_op("op_xor", 3'b100, 4'b1100, 1'b0);
        expect_op("op_not", 3'b101, 4'b0101, 1'b0);
        expect_op("op_pasa", 3'b110, 4'b1010, 1'b0);
        expect_op("op_pasb", 3'b111, 4'b0110, 1'b0);
        tick();
        expect_op("op_add16", 3'b010, 4'b0000, 1'b1);
        expect_op("op_sub", 3'b011, 4'b0100, 1'b0);

        // Mid-stream reset beats any select
        sel21 = 1'b1; sel12 = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; sel21 = 1'b0; dados = 4'b0000; sel12 = 1'b0;
        expect_op("rst_pasa", 3'b110, 4'b0000, 1'b0);
        expect_op("rst_pasb", 3'b111, 4'b0000, 1'b0);
        expect_op("rst_not", 3'b101, 4'b1111, 1'b0);
        tick();
        tick();
        expect_op("rst_after", 3'b010, 4'b0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
